uart_tx: RTL and testbench

UART transmitter for the AES link: serialises bytes (8N1 by default) onto `data_tx` at `BAUDRATE`, using the same bit timing as `uart_rx` so the two loop back cleanly. A 16-entry input FIFO lets the AES core hand over a full 128-bit ciphertext block in 16 consecutive cycles. The FIFO then drains it as gap-free back-to-back frames. It sits between the AES output formatter and the board TX pin.

---
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter with a small input FIFO.
// Bytes written through data_in/data_in_valid are queued and sent LSB first as
// start(0) + DATA_BIT_LENGTH data bits + stop(1). Each line bit lasts
// CLK_FREQ/BAUDRATE clocks. Frames drain back to back with no idle gap
// between them.
module uart_tx #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int BAUDRATE        = 115_200,
  parameter int DATA_BIT_LENGTH = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_BIT_LENGTH-1:0] data_in,
  input  logic                       data_in_valid,
  output logic                       fifo_full,
  output logic                       tx_busy,
  output logic                       data_tx,
  output logic                       data_tx_done
);

  localparam int BIT_PERIOD_CLKS = CLK_FREQ / BAUDRATE;
  localparam int CNT_W   = (BIT_PERIOD_CLKS > 1) ? $clog2(BIT_PERIOD_CLKS) : 1;
  localparam int IDX_W   = (DATA_BIT_LENGTH > 1) ? $clog2(DATA_BIT_LENGTH) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int PTR_LEN = PTR_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIT_PERIOD_CLKS - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BIT_LENGTH - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);
  localparam logic [PTR_LEN-1:0] DEPTH_P  = PTR_LEN'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO: circular buffer, pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate counter.
  // ---------------------------------------------------------------------------
  logic [DATA_BIT_LENGTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_LEN-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [PTR_LEN-1:0]         wr_ptr_next, rd_ptr_next, count_next;
  logic                       fifo_full_reg;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [DATA_BIT_LENGTH-1:0] fifo_head;

  // A write while full is simply ignored, even if a pop frees a slot on the
  // same edge; fullness is judged from the registered flag only.
  assign push        = data_in_valid && !fifo_full_reg;
  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_head   = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign wr_ptr_next = push ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
  assign rd_ptr_next = pop  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
  assign count_next  = wr_ptr_next - rd_ptr_next;

  // Storage array: no reset, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= data_in;
    end
  end

  // Pointer and full-flag registers; full tracks the post-edge occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_full_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      fifo_full_reg <= (count_next == DEPTH_P);
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t                     state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [DATA_BIT_LENGTH-1:0] shift_reg, shift_next;
  logic                       tx_reg, tx_next;
  logic                       bit_end;

  assign bit_end = (cnt_reg == CNT_LAST);

  // State register; reset forces the line high at once, aborting any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: the line value is registered and changes exactly on
  // bit boundaries; a pop loads the shift register and starts the start bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          tx_next    = 1'b0;
          cnt_next   = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = shift_reg[0];
          state_next = S_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          if (idx_reg == IDX_LAST) begin
            tx_next    = 1'b1;
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + IDX_ONE;
            tx_next  = shift_next[0];
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            tx_next    = 1'b0;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign data_tx      = tx_reg;
  assign fifo_full    = fifo_full_reg;
  assign tx_busy      = (state_reg != S_IDLE) || !fifo_empty;
  assign data_tx_done = (state_reg == S_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx. The driver pushes every byte it expects the
// transmitter to accept; an independent line monitor decodes frames from
// data_tx sample by sample and pops/compares against that queue.
module tb_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUDRATE = 100;
  localparam int DBL      = 8;
  localparam int DEPTH    = 16;
  localparam int P        = CLK_FREQ / BAUDRATE;
  localparam int FRAME    = (DBL + 2) * P;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DBL-1:0] data_in = '0;
  logic           data_in_valid = 1'b0;
  logic           fifo_full;
  logic           tx_busy;
  logic           data_tx;
  logic           data_tx_done;

  uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUDRATE(BAUDRATE),
    .DATA_BIT_LENGTH(DBL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .fifo_full(fifo_full),
    .tx_busy(tx_busy),
    .data_tx(data_tx),
    .data_tx_done(data_tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DBL-1:0] exp_q[$];
  int             accepted = 0;
  int             frames_started = 0;
  int             starts[$];
  int             done_cycs[$];
  int             stray_done = 0;
  int             last_wr_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor: samples on the falling edge, one sample per clock.
  // ---------------------------------------------------------------------------
  int               mon_pos = -1;
  logic [DBL+1:0]   line_bits;
  bit               shape_ok;
  int               done_cnt;
  int               done_pos;
  int               bi;
  logic [DBL-1:0]   got_byte;
  logic [DBL-1:0]   exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pos = -1;
    end else begin
      if (mon_pos < 0) begin
        if (data_tx === 1'b0) begin
          mon_pos  = 0;
          shape_ok = 1'b1;
          done_cnt = 0;
          done_pos = -1;
          starts.push_back(cyc);
          frames_started++;
        end else if (data_tx_done) begin
          stray_done++;
        end
      end
      if (mon_pos >= 0) begin
        bi = mon_pos / P;
        if ((mon_pos % P) == 0) line_bits[bi] = data_tx;
        else if (data_tx !== line_bits[bi]) shape_ok = 1'b0;
        if (data_tx_done) begin
          done_cnt++;
          done_pos = mon_pos;
          done_cycs.push_back(cyc);
        end
        mon_pos++;
        if (mon_pos == FRAME) begin
          mon_pos  = -1;
          got_byte = line_bits[DBL:1];
          $display("frame at cycle %0d: byte 0x%02h", starts[starts.size()-1], got_byte);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: actual byte 0x%02h required no frame", got_byte);
          end else begin
            exp_byte = exp_q.pop_front();
            check("frame_byte", int'(got_byte), int'(exp_byte));
          end
          check("frame_shape", int'(shape_ok && line_bits[DBL+1]), 1);
          check("done_pulse_pos", (done_cnt == 1) ? done_pos : -1, FRAME - 1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers: all driving happens just after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [DBL-1:0] b);
    int occ;
    occ = accepted - frames_started;
    check("fifo_full", int'(fifo_full), int'(occ == DEPTH));
    data_in       = b;
    data_in_valid = 1'b1;
    last_wr_cyc   = cyc + 1;
    if (occ < DEPTH) begin
      exp_q.push_back(b);
      accepted++;
      $display("write 0x%02h accepted at cycle %0d", b, last_wr_cyc);
    end else begin
      $display("write 0x%02h dropped at cycle %0d (queue full)", b, last_wr_cyc);
    end
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic wait_mon(input int pos, input int limit);
    int g;
    for (g = 0; g < limit && mon_pos < pos; g++) tick();
    if (mon_pos < pos) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_timeout: actual mon_pos=%0d required>=%0d", mon_pos, pos);
    end
  endtask

  task automatic wait_drain(input int limit);
    int g;
    for (g = 0; g < limit && !(exp_q.size() == 0 && mon_pos < 0); g++) tick();
    if (!(exp_q.size() == 0 && mon_pos < 0)) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
    check("idle_busy", int'(tx_busy), 0);
    check("idle_line", int'(data_tx), 1);
  endtask

  task automatic wait_cyc(input int target);
    int g;
    for (g = 0; g < 4 * FRAME && cyc < target; g++) tick();
    check("cycle_align", cyc, target);
  endtask

  int s0;
  int d0;
  int a0;
  int dc0;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_data_tx", int'(data_tx), 1);
    check("rst_tx_busy", int'(tx_busy), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_done", int'(data_tx_done), 0);
    rst_n = 1'b1;
    tick();

    // Single 0x55: latency and done timing
    s0 = starts.size();
    d0 = done_cycs.size();
    wr(8'h55);
    check("busy_after_write", int'(tx_busy), 1);
    wait_drain(FRAME + 20);
    check("start_latency", (starts.size() > s0) ? starts[s0] - last_wr_cyc : -1, 1);
    check("done_cycle", (done_cycs.size() > d0) ? done_cycs[d0] - last_wr_cyc : -1, FRAME);

    // Back to back 0x55 then 0xA3 written during the first frame
    s0 = starts.size();
    d0 = done_cycs.size();
    wr(8'h55);
    wait_mon(20, FRAME);
    wr(8'hA3);
    wait_drain(2 * FRAME + 20);
    check("b2b_start_gap", (starts.size() > s0 + 1) ? starts[s0+1] - starts[s0] : -1, FRAME);
    check("b2b_done_gap", (done_cycs.size() > d0 + 1) ? done_cycs[d0+1] - done_cycs[d0] : -1, FRAME);

    // Overflow: 17 writes while a frame is in flight
    wr(8'hEE);
    wait_mon(5, FRAME);
    for (int k = 0; k < 17; k++) wr(DBL'(k));
    check("overflow_full", int'(fifo_full), 1);
    wait_drain(19 * FRAME + 50);

    // Write coinciding with a pop from a one-entry FIFO
    s0 = starts.size();
    wr(8'h3C);
    wait_mon(5, FRAME);
    wr(8'hC3);
    wait_cyc(starts[starts.size()-1] + FRAME - 1);
    wr(8'h5A);
    check("simul_busy", int'(tx_busy), 1);
    wait_drain(3 * FRAME + 50);
    check("simul_gap1", (starts.size() > s0 + 1) ? starts[s0+1] - starts[s0] : -1, FRAME);
    check("simul_gap2", (starts.size() > s0 + 2) ? starts[s0+2] - starts[s0+1] : -1, FRAME);

    // Sixteen consecutive random writes into an idle block
    s0 = starts.size();
    a0 = accepted;
    for (int k = 0; k < 16; k++) wr(DBL'($urandom_range(0, 255)));
    check("burst_accepted", accepted - a0, 16);
    wait_drain(16 * FRAME + 50);
    for (int k = 1; k < 16; k++)
      check("burst_gap", (starts.size() > s0 + k) ? starts[s0+k] - starts[s0+k-1] : -1, FRAME);

    // Random traffic with random idle gaps
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 150)) tick();
      wr(DBL'($urandom));
    end
    wait_drain(41 * FRAME + 200);

    // Reset during data bit 3 of 0xA3 with five bytes queued
    wr(8'hA3);
    wait_mon(1, FRAME);
    for (int k = 0; k < 5; k++) wr(DBL'($urandom_range(0, 255)));
    wait_cyc(starts[starts.size()-1] + 4 * P + P / 2);
    check("pre_rst_line_low", int'(data_tx), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_data_tx", int'(data_tx), 1);
    check("midrst_tx_busy", int'(tx_busy), 0);
    check("midrst_fifo_full", int'(fifo_full), 0);
    check("midrst_done", int'(data_tx_done), 0);
    exp_q.delete();
    accepted       = 0;
    frames_started = 0;
    dc0            = done_cycs.size();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3 * FRAME) tick();
    check("postrst_frames", frames_started, 0);
    check("postrst_done", done_cycs.size() - dc0, 0);
    check("postrst_busy", int'(tx_busy), 0);
    check("postrst_line", int'(data_tx), 1);
    check("postrst_full", int'(fifo_full), 0);

    check("stray_done", stray_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
